// File: rtl/y86_fetch_pipe_pkg.sv
//------------------------------------------------------------------------------
// Module   : y86_pkg
// Brief    : Y86-64 icode, register and status constants plus D-register type
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_t;

    typedef struct packed {
        stat_t       stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
    } d_reg_t;

    localparam d_reg_t c_d_bubble = '{
        stat:  STAT_AOK,
        icode: INOP,
        ifun:  4'h0,
        rA:    RNONE,
        rB:    RNONE,
        valC:  64'd0,
        valP:  64'd0
    };

endpackage

`default_nettype wire

// File: rtl/y86_fetch_pipe_if.sv
//------------------------------------------------------------------------------
// Module   : y86_fetch_pipe_if
// Brief    : Load port, pipeline control/redirect inputs and D-register outputs
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface y86_fetch_pipe_if #(
    parameter int IMEM_AW = 11
);
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [7:0]         imem_wdata;

    logic               F_stall;
    logic               D_stall;
    logic               D_bubble;
    logic [3:0]         M_icode;
    logic               M_Cnd;
    logic [63:0]        M_valA;
    logic [3:0]         W_icode;
    logic [63:0]        W_valM;

    logic [63:0]        f_pc;
    logic [1:0]         D_stat;
    logic [3:0]         D_icode;
    logic [3:0]         D_ifun;
    logic [3:0]         D_rA;
    logic [3:0]         D_rB;
    logic [63:0]        D_valC;
    logic [63:0]        D_valP;

    modport master (
        output imem_we, imem_waddr, imem_wdata,
        output F_stall, D_stall, D_bubble,
        output M_icode, M_Cnd, M_valA, W_icode, W_valM,
        input  f_pc, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP
    );

    modport slave (
        input  imem_we, imem_waddr, imem_wdata,
        input  F_stall, D_stall, D_bubble,
        input  M_icode, M_Cnd, M_valA, W_icode, W_valM,
        output f_pc, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP
    );

endinterface

`default_nettype wire

// File: rtl/y86_fetch_decode.sv
//------------------------------------------------------------------------------
// Module   : y86_fetch_decode
// Brief    : Instruction validity and length flags from icode/ifun
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module y86_fetch_decode
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    input  logic [3:0] i_ifun,
    output logic       o_instr_valid,
    output logic       o_need_regids,
    output logic       o_need_valC
);

    always_comb begin
        o_instr_valid = 1'b0;
        o_need_regids = 1'b0;
        o_need_valC   = 1'b0;
        case (i_icode)
            IHALT, INOP, IRET: begin
                o_instr_valid = (i_ifun == 4'h0);
            end
            IRRMOVQ: begin
                o_need_regids = 1'b1;
                o_instr_valid = (i_ifun <= 4'h6);
            end
            IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
                o_need_regids = 1'b1;
                o_need_valC   = 1'b1;
                o_instr_valid = (i_ifun == 4'h0);
            end
            IOPQ: begin
                o_need_regids = 1'b1;
                o_instr_valid = (i_ifun <= 4'h3);
            end
            IJXX: begin
                o_need_valC   = 1'b1;
                o_instr_valid = (i_ifun <= 4'h6);
            end
            ICALL: begin
                o_need_valC   = 1'b1;
                o_instr_valid = (i_ifun == 4'h0);
            end
            IPUSHQ, IPOPQ: begin
                o_need_regids = 1'b1;
                o_instr_valid = (i_ifun == 4'h0);
            end
            default: begin
                o_instr_valid = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/y86_fetch_pipe.sv
//------------------------------------------------------------------------------
// Module   : y86_fetch_pipe
// Brief    : Y86-64 pipelined fetch: F register, PC select, imem, decode, D reg.
//            FETCH_PERF_EN adds saturating perf_fetched/perf_stall counters.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module y86_fetch_pipe
    import y86_pkg::*;
#(
    parameter int          IMEM_DEPTH = 2048,
    parameter int          IMEM_AW    = 11,
    parameter logic [63:0] RESET_PC   = 64'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    y86_fetch_pipe_if.slave bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam logic [64:0] c_depth = 65'(IMEM_DEPTH);

    logic [7:0]  r_mem [IMEM_DEPTH];
    logic [63:0] r_pred_pc;
    d_reg_t      r_d;

    logic [63:0] w_f_pc;
    logic [7:0]  w_bytes [10];
    logic [3:0]  w_icode_raw;
    logic [3:0]  w_ifun_raw;
    logic        w_instr_valid;
    logic        w_need_regids;
    logic        w_need_valC;
    logic [3:0]  w_len;
    logic        w_imem_error;
    logic [7:0]  w_regids;
    logic [63:0] w_valC;
    logic [63:0] w_valP;
    logic [3:0]  w_icode;
    logic [3:0]  w_ifun;
    stat_t       w_stat;
    logic [63:0] w_pred_pc;
    d_reg_t      w_d_next;

    always_ff @(posedge clk) begin
        if (bus.imem_we && (65'(bus.imem_waddr) < c_depth)) begin
            r_mem[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    // A taken-predicted jump that turned out not taken beats a pending ret.
    always_comb begin
        w_f_pc = r_pred_pc;
        if ((bus.M_icode == IJXX) && !bus.M_Cnd) begin
            w_f_pc = bus.M_valA;
        end else if (bus.W_icode == IRET) begin
            w_f_pc = bus.W_valM;
        end
    end

    // Ten byte lanes cover the longest instruction; lanes past the end read 0.
    generate
        for (genvar i = 0; i < 10; i++) begin : g_fetch_byte
            logic [64:0] w_addr;
            assign w_addr     = {1'b0, w_f_pc} + 65'(i);
            assign w_bytes[i] = (w_addr < c_depth) ? r_mem[w_addr[IMEM_AW-1:0]] : 8'h00;
        end
    endgenerate

    assign w_icode_raw = w_bytes[0][7:4];
    assign w_ifun_raw  = w_bytes[0][3:0];

    y86_fetch_decode u_decode (
        .i_icode       (w_icode_raw),
        .i_ifun        (w_ifun_raw),
        .o_instr_valid (w_instr_valid),
        .o_need_regids (w_need_regids),
        .o_need_valC   (w_need_valC)
    );

    assign w_len        = 4'd1 + {3'b000, w_need_regids} + {w_need_valC, 3'b000};
    assign w_imem_error = ({1'b0, w_f_pc} >= c_depth) ||
                          (({1'b0, w_f_pc} + 65'(w_len)) > c_depth);
    assign w_valP       = w_f_pc + 64'(w_len);
    assign w_regids     = w_need_regids ? w_bytes[1] : {RNONE, RNONE};

    always_comb begin
        w_valC = 64'd0;
        if (w_need_valC) begin
            for (int k = 0; k < 8; k++) begin
                w_valC[8*k +: 8] = w_need_regids ? w_bytes[k+2] : w_bytes[k+1];
            end
        end
    end

    assign w_icode = w_imem_error ? INOP : w_icode_raw;
    assign w_ifun  = w_imem_error ? 4'h0 : w_ifun_raw;

    always_comb begin
        w_stat = STAT_AOK;
        if (w_imem_error) begin
            w_stat = STAT_ADR;
        end else if (!w_instr_valid) begin
            w_stat = STAT_INS;
        end else if (w_icode == IHALT) begin
            w_stat = STAT_HLT;
        end
    end

    assign w_pred_pc = ((w_icode == IJXX) || (w_icode == ICALL)) ? w_valC : w_valP;

    assign w_d_next = '{
        stat:  w_stat,
        icode: w_icode,
        ifun:  w_ifun,
        rA:    w_regids[7:4],
        rB:    w_regids[3:0],
        valC:  w_valC,
        valP:  w_valP
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_pc <= RESET_PC;
        end else if (!bus.F_stall) begin
            r_pred_pc <= w_pred_pc;
        end
    end

    // Stall has priority over bubble so a held instruction is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d <= c_d_bubble;
        end else if (bus.D_stall) begin
            r_d <= r_d;
        end else if (bus.D_bubble) begin
            r_d <= c_d_bubble;
        end else begin
            r_d <= w_d_next;
        end
    end

    assign bus.f_pc    = w_f_pc;
    assign bus.D_stat  = r_d.stat;
    assign bus.D_icode = r_d.icode;
    assign bus.D_ifun  = r_d.ifun;
    assign bus.D_rA    = r_d.rA;
    assign bus.D_rB    = r_d.rB;
    assign bus.D_valC  = r_d.valC;
    assign bus.D_valP  = r_d.valP;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= 32'd0;
            r_perf_stall   <= 32'd0;
        end else begin
            if (!bus.D_stall && !bus.D_bubble && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (bus.F_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

`default_nettype wire
